// File: rtl/clock_pkg.sv
// Shared types and timing defaults for the clock/calendar chain
// (seconds/minutes now, hour/alarm blocks later).
package clock_pkg;

    localparam int CLK_HZ_DEF          = 50_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = 500_000;
    localparam int REPEAT_DELAY_DEF    = 25_000_000;
    localparam int REPEAT_PERIOD_DEF   = 5_000_000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } adj_state_e;

    // Bits needed for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for the adjust button.
// level_o is the registered debounced level; rise_o flags the edge at which it will rise.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic clear,
    input  logic btn_raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;

    assign accept = (s2_q != level_q) && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        cnt_d   = '0;
        level_d = level_q;
        if (s2_q != level_q) begin
            if (accept) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            // NOTE: s1_q may go metastable on the asynchronous input; only s2_q feeds logic.
            s1_q    <= btn_raw_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational so the top can register its press pulse on the same edge the level rises.
    assign rise_o  = accept && s2_q;
    assign level_o = level_q;

endmodule

// File: rtl/clock_tick_ctrl.sv
// Seconds prescaler and adjust-button pulse generator (press, delay, auto-repeat)
// feeding the counter60 chain; time is frozen while the button is held.
module clock_tick_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ          = CLK_HZ_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic clear,
    input  logic run_en,
    input  logic btn_raw,
    output logic sec_tick,
    output logic adj_pulse,
    output logic adj_held
);

    localparam int PW = cnt_width(CLK_HZ);
    localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_LOAD   = RW'(REPEAT_PERIOD - 1);

    logic          level;
    logic          rise;
    adj_state_e    state_q;
    logic [RW-1:0] rpt_q;
    logic          adj_pulse_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          sec_tick_q;
    logic          sec_tick_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .clear    (clear),
        .btn_raw_i(btn_raw),
        .level_o  (level),
        .rise_o   (rise)
    );

    // rpt_q counts down to zero; a pulse fires on the edge it is found at zero.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            rpt_q       <= '0;
            adj_pulse_q <= 1'b0;
        end else begin
            adj_pulse_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        adj_pulse_q <= 1'b1;
                        rpt_q       <= DELAY_LOAD;
                        state_q     <= ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!level) begin
                        // Release beats a coincident expiry: no pulse on let-go.
                        rpt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (rpt_q == '0) begin
                        adj_pulse_q <= 1'b1;
                        rpt_q       <= RPT_LOAD;
                        state_q     <= ST_REPEAT;
                    end else begin
                        rpt_q <= rpt_q - RW'(1);
                    end
                end
                default: begin
                    rpt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Gating on rise as well as level keeps a tick from landing on the press pulse.
    always_comb begin
        presc_d    = presc_q;
        sec_tick_d = 1'b0;
        if (level || rise) begin
            presc_d = '0;
        end else if (run_en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d    = '0;
                sec_tick_d = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign sec_tick  = sec_tick_q;
    assign adj_pulse = adj_pulse_q;
    assign adj_held  = level;

endmodule

// File: tb/tb_clock_tick_ctrl.sv
// Directed bench for clock_tick_ctrl: expected pulse cycles are queued as stimulus
// is applied and every cycle the outputs are compared against the queue heads.
module tb_clock_tick_ctrl;

    logic clk = 1'b0;
    logic clear;
    logic run_en;
    logic btn_raw;
    logic sec_tick;
    logic adj_pulse;
    logic adj_held;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int exp_tick[$];
    int exp_adj[$];

    int c0, c1, c3, p, q, r;

    clock_tick_ctrl #(
        .CLK_HZ         (10),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .run_en   (run_en),
        .btn_raw  (btn_raw),
        .sec_tick (sec_tick),
        .adj_pulse(adj_pulse),
        .adj_held (adj_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard: a pulse is expected exactly on the cycles at the head of each queue.
    always @(negedge clk) begin
        if (exp_tick.size() != 0 && exp_tick[0] == cyc) begin
            void'(exp_tick.pop_front());
            check("sec_tick", 32'(sec_tick), 32'd1);
        end else begin
            check("sec_tick", 32'(sec_tick), 32'd0);
        end
        if (exp_adj.size() != 0 && exp_adj[0] == cyc) begin
            void'(exp_adj.pop_front());
            check("adj_pulse", 32'(adj_pulse), 32'd1);
        end else begin
            check("adj_pulse", 32'(adj_pulse), 32'd0);
        end
    end

    initial begin
        clear   = 1'b1;
        run_en  = 1'b0;
        btn_raw = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sec_tick", 32'(sec_tick), 32'd0);
        check("rst_adj_pulse", 32'(adj_pulse), 32'd0);
        check("rst_adj_held", 32'(adj_held), 32'd0);

        // Free-running seconds with the button idle.
        c0 = cyc;
        clear  = 1'b0;
        run_en = 1'b1;
        exp_tick.push_back(c0 + 10);
        exp_tick.push_back(c0 + 20);
        exp_tick.push_back(c0 + 30);

        // Short press: one pulse, ticks frozen, restart CLK_HZ after release.
        wait_until(c0 + 33);
        c1 = cyc;
        btn_raw = 1'b1;
        exp_adj.push_back(c1 + 6);
        exp_tick.push_back(c1 + 28);
        wait_until(c1 + 5);
        check("press_held_early", 32'(adj_held), 32'd0);
        wait_until(c1 + 6);
        check("press_held_rise", 32'(adj_held), 32'd1);
        wait_until(c1 + 12);
        btn_raw = 1'b0;
        wait_until(c1 + 17);
        check("press_held_late", 32'(adj_held), 32'd1);
        wait_until(c1 + 18);
        check("press_held_fall", 32'(adj_held), 32'd0);

        // Glitch train: three high cycles never satisfy a four-cycle debounce.
        wait_until(c1 + 30);
        exp_tick.push_back(c1 + 38);
        exp_tick.push_back(c1 + 48);
        for (int i = 0; i < 5; i++) begin
            btn_raw = 1'b1;
            repeat (3) @(negedge clk);
            btn_raw = 1'b0;
            @(negedge clk);
        end
        wait_until(c1 + 56);
        check("glitch_held", 32'(adj_held), 32'd0);

        // Long hold with auto-repeat; release coincides with the offset-50 expiry.
        c3 = cyc;
        p  = c3 + 6;
        btn_raw = 1'b1;
        exp_tick.push_back(c3 + 2);
        exp_adj.push_back(p);
        for (int k = 0; k < 6; k++) exp_adj.push_back(p + 20 + 5 * k);
        exp_tick.push_back(p + 59);
        exp_tick.push_back(p + 76);
        exp_tick.push_back(p + 86);
        wait_until(p + 43);
        btn_raw = 1'b0;
        wait_until(p + 48);
        check("hold_held_late", 32'(adj_held), 32'd1);
        wait_until(p + 49);
        check("hold_held_fall", 32'(adj_held), 32'd0);

        // Freeze the prescaler at count 6 for seven edges.
        wait_until(p + 65);
        run_en = 1'b0;
        wait_until(p + 72);
        run_en = 1'b1;

        // Clear during REPEAT with the button still down, then full re-acquisition.
        wait_until(p + 88);
        q = cyc + 6;
        btn_raw = 1'b1;
        exp_adj.push_back(q);
        exp_adj.push_back(q + 20);
        exp_adj.push_back(q + 25);
        wait_until(q + 27);
        check("pre_clear_held", 32'(adj_held), 32'd1);
        clear = 1'b1;
        #1;
        check("clear_sec_tick", 32'(sec_tick), 32'd0);
        check("clear_adj_pulse", 32'(adj_pulse), 32'd0);
        check("clear_adj_held", 32'(adj_held), 32'd0);
        wait_until(q + 30);
        r = cyc;
        clear = 1'b0;
        exp_adj.push_back(r + 6);
        exp_adj.push_back(r + 26);
        exp_adj.push_back(r + 31);
        exp_adj.push_back(r + 36);
        exp_tick.push_back(r + 49);
        exp_tick.push_back(r + 59);
        wait_until(r + 5);
        check("reacq_held_early", 32'(adj_held), 32'd0);
        wait_until(r + 6);
        check("reacq_held_rise", 32'(adj_held), 32'd1);
        wait_until(r + 33);
        btn_raw = 1'b0;
        wait_until(r + 39);
        check("reacq_held_fall", 32'(adj_held), 32'd0);
        wait_until(r + 62);

        check("tick_queue_drained", 32'(exp_tick.size()), 32'd0);
        check("adj_queue_drained", 32'(exp_adj.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
